// File: rtl/dino_motion_ctrl.sv
// Vertical-motion controller for the dino sprite: game-state machine
// (idle/run/air/dead), jump physics, shared physics tick and leg-animation
// frame select. Every output is taken straight from a register.
module dino_motion_ctrl #(
    parameter int GROUND_Y    = 240,
    parameter int MIN_Y       = 49,
    parameter int JUMP_V0     = 12,
    parameter int GRAVITY     = 1,
    parameter int TICK_CYCLES = 1666667,
    parameter int ANIM_TICKS  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_jump,
    input  logic       i_collide,
    output logic [9:0] o_pos,
    output logic [1:0] o_state,
    output logic       o_airborne,
    output logic       o_run_frame,
    output logic       o_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_AIR  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam int TCW = $clog2(TICK_CYCLES);
    localparam int ACW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

    localparam logic [TCW-1:0]     TICK_LAST = TCW'(TICK_CYCLES - 1);
    // tick is registered, so it is raised one count early
    localparam logic [TCW-1:0]     TICK_PRE  = TCW'(TICK_CYCLES - 2);
    localparam logic [ACW-1:0]     ANIM_LAST = ACW'(ANIM_TICKS - 1);
    localparam logic [9:0]         GROUND_P  = 10'(GROUND_Y);
    localparam logic [9:0]         MIN_P     = 10'(MIN_Y);
    localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
    localparam logic signed [10:0] MIN_S     = 11'(MIN_Y);
    localparam logic signed [7:0]  V0_S      = 8'(JUMP_V0);
    localparam logic signed [7:0]  GRAV_S    = 8'(GRAVITY);

    state_t                r_state;
    logic [TCW-1:0]        r_tick_cnt;
    logic                  r_tick;
    logic [9:0]            r_pos;
    logic signed [7:0]     r_vel;
    logic                  r_jreq;
    logic                  r_jump_d;
    logic [ACW-1:0]        r_anim_cnt;
    logic                  r_run_frame;
    logic                  r_airborne;

    state_t                w_state_nxt;
    logic [9:0]            w_pos_nxt;
    logic signed [7:0]     w_vel_nxt;
    logic                  w_jreq_nxt;
    logic [ACW-1:0]        w_anim_nxt;
    logic                  w_frame_nxt;
    logic                  w_jump_rise;
    logic signed [10:0]    w_nxt;

    assign w_jump_rise = i_jump & ~r_jump_d;
    // Candidate position: positive velocity moves the sprite up the screen
    assign w_nxt = $signed({1'b0, r_pos}) - $signed({{3{r_vel[7]}}, r_vel});

    // Free-running tick counter and registered tick pulse; runs in every state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TCW'(1);
            r_tick     <= (r_tick_cnt == TICK_PRE);
        end
    end

    // Next-state, physics and animation; collide outranks the tick update
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_vel_nxt   = r_vel;
        w_anim_nxt  = r_anim_cnt;
        w_frame_nxt = r_run_frame;
        case (r_state)
            ST_IDLE: begin
                w_pos_nxt   = GROUND_P;
                w_vel_nxt   = 8'sd0;
                w_anim_nxt  = '0;
                w_frame_nxt = 1'b0;
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_collide) begin
                    w_state_nxt = ST_DEAD;
                end else if (r_tick) begin
                    if (r_anim_cnt == ANIM_LAST) begin
                        w_anim_nxt  = '0;
                        w_frame_nxt = ~r_run_frame;
                    end else begin
                        w_anim_nxt  = r_anim_cnt + ACW'(1);
                    end
                    if (r_jreq) begin
                        w_state_nxt = ST_AIR;
                        w_vel_nxt   = V0_S;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_AIR: begin
                if (i_collide) begin
                    w_state_nxt = ST_DEAD;
                end else if (r_tick) begin
                    if (w_nxt >= GROUND_S) begin
                        w_pos_nxt   = GROUND_P;
                        w_vel_nxt   = 8'sd0;
                        w_state_nxt = ST_RUN;
                    end else if (w_nxt < MIN_S) begin
                        w_pos_nxt   = MIN_P;
                        w_vel_nxt   = 8'sd0;
                    end else begin
                        w_pos_nxt   = w_nxt[9:0];
                        w_vel_nxt   = r_vel - GRAV_S;
                    end
                end else begin
                    w_state_nxt = ST_AIR;
                end
            end
            ST_DEAD: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_pos_nxt   = GROUND_P;
                    w_vel_nxt   = 8'sd0;
                    w_anim_nxt  = '0;
                    w_frame_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_DEAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pos_nxt   = GROUND_P;
                w_vel_nxt   = 8'sd0;
                w_anim_nxt  = '0;
                w_frame_nxt = 1'b0;
            end
        endcase
    end

    // Jump request only accumulates while staying in RUN; any transition
    // (including the launch that consumes it) drops it
    always_comb begin
        if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            w_jreq_nxt = r_jreq | w_jump_rise;
        end else begin
            w_jreq_nxt = 1'b0;
        end
    end

    // State, physics and animation registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= GROUND_P;
            r_vel       <= 8'sd0;
            r_jreq      <= 1'b0;
            r_jump_d    <= 1'b0;
            r_anim_cnt  <= '0;
            r_run_frame <= 1'b0;
            r_airborne  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_vel       <= w_vel_nxt;
            r_jreq      <= w_jreq_nxt;
            r_jump_d    <= i_jump;
            r_anim_cnt  <= w_anim_nxt;
            r_run_frame <= w_frame_nxt;
            r_airborne  <= (w_state_nxt == ST_AIR);
        end
    end

    assign o_pos       = r_pos;
    assign o_state     = r_state;
    assign o_airborne  = r_airborne;
    assign o_run_frame = r_run_frame;
    assign o_tick      = r_tick;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed self-checking bench for dino_motion_ctrl with a 4-cycle tick.
// u_dut uses the default trajectory, u_ceil a launch velocity of 100.
module tb_dino_motion_ctrl;

    logic       clk;
    logic       rst;
    logic       m_start, m_jump, m_collide;
    logic       c_start, c_jump, c_collide;
    logic [9:0] m_pos, c_pos;
    logic [1:0] m_state, c_state;
    logic       m_air, c_air, m_frame, c_frame, m_tick, c_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_pos [0:25];

    dino_motion_ctrl #(
        .GROUND_Y(240), .MIN_Y(49), .JUMP_V0(12), .GRAVITY(1),
        .TICK_CYCLES(4), .ANIM_TICKS(6)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(m_start), .i_jump(m_jump),
        .i_collide(m_collide), .o_pos(m_pos), .o_state(m_state),
        .o_airborne(m_air), .o_run_frame(m_frame), .o_tick(m_tick)
    );

    dino_motion_ctrl #(
        .GROUND_Y(240), .MIN_Y(49), .JUMP_V0(100), .GRAVITY(1),
        .TICK_CYCLES(4), .ANIM_TICKS(6)
    ) u_ceil (
        .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_jump(c_jump),
        .i_collide(c_collide), .o_pos(c_pos), .o_state(c_state),
        .o_airborne(c_air), .o_run_frame(c_frame), .o_tick(c_tick)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge after the next tick-high cycle (update visible)
    task automatic step_tick(input bit which);
        int seen;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if ((which ? c_tick : m_tick) == 1'b1) begin
                seen = 1;
                break;
            end
        end
        check_val("tick_seen", seen, 1);
        @(negedge clk);
    endtask

    // Wait (bounded) until the selected instance reaches a given state
    task automatic wait_state(input bit which, input int want, input string tag);
        int st;
        st = which ? int'(c_state) : int'(m_state);
        for (int i = 0; i < 40 && st != want; i++) begin
            @(negedge clk);
            st = which ? int'(c_state) : int'(m_state);
        end
        check_val(tag, st, want);
    endtask

    initial begin
        int n;
        exp_pos = '{240, 228, 217, 207, 198, 190, 183, 177, 172, 168, 165, 163, 162,
                    162, 163, 165, 168, 172, 177, 183, 190, 198, 207, 217, 228, 240};
        clk = 1'b0; rst = 1'b1;
        m_start = 1'b0; m_jump = 1'b0; m_collide = 1'b0;
        c_start = 1'b0; c_jump = 1'b0; c_collide = 1'b0;

        // Reset and tick phase
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pos", m_pos, 240);
        check_val("rst_state", m_state, 0);
        check_val("rst_frame", m_frame, 0);
        check_val("rst_air", m_air, 0);
        check_val("rst_tick", m_tick, 0);
        rst = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            check_val($sformatf("tick_c%0d", k), m_tick, (k % 4 == 3) ? 1 : 0);
        end

        // Start, then full jump with the button held through the landing
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        check_val("start_run", m_state, 1);
        m_jump = 1'b1;
        wait_state(1'b0, 2, "launch_state");
        check_val("launch_pos", m_pos, 240);
        check_val("launch_air", m_air, 1);
        for (int i = 1; i <= 25; i++) begin
            step_tick(1'b0);
            check_val($sformatf("traj_pos_t%0d", i), m_pos, exp_pos[i]);
            check_val($sformatf("traj_state_t%0d", i), m_state, (i < 25) ? 2 : 1);
        end

        // Held button: no auto-repeat
        for (int i = 0; i < 3; i++) begin
            step_tick(1'b0);
            check_val("held_no_jump", m_state, 1);
        end

        // Release and press again: new jump, then collide on the tick at 207
        m_jump = 1'b0;
        @(negedge clk);
        m_jump = 1'b1;
        wait_state(1'b0, 2, "rejump_state");
        for (int i = 0; i < 3; i++) step_tick(1'b0);
        check_val("pre_collide_pos", m_pos, 207);
        n = 0;
        while (m_tick == 1'b0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_val("collide_tick_seen", m_tick, 1);
        m_collide = 1'b1;
        @(negedge clk);
        m_collide = 1'b0;
        check_val("dead_state", m_state, 3);
        check_val("dead_pos", m_pos, 207);
        check_val("dead_air", m_air, 0);
        step_tick(1'b0);
        step_tick(1'b0);
        check_val("dead_hold_pos", m_pos, 207);
        check_val("dead_hold_state", m_state, 3);
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        check_val("restart_state", m_state, 1);
        check_val("restart_pos", m_pos, 240);
        check_val("restart_frame", m_frame, 0);

        // Animation: frame toggles every 6 ticks = 24 cycles (button still held)
        n = 0;
        while (m_frame == 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("anim_first", m_frame, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_frame == 1'b1 && n < 60);
        check_val("anim_period", n, 24);
        check_val("anim_still_run", m_state, 1);

        // Reset mid-air
        m_jump = 1'b0;
        @(negedge clk);
        m_jump = 1'b1;
        wait_state(1'b0, 2, "air_before_rst");
        step_tick(1'b0);
        step_tick(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midair_rst_state", m_state, 0);
        check_val("midair_rst_pos", m_pos, 240);
        check_val("midair_rst_air", m_air, 0);
        m_jump = 1'b0;

        // Ceiling clamp with V0=100
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        check_val("ceil_start", c_state, 1);
        c_jump = 1'b1;
        wait_state(1'b1, 2, "ceil_launch");
        step_tick(1'b1);
        check_val("ceil_t1_pos", c_pos, 140);
        step_tick(1'b1);
        check_val("ceil_clamp_pos", c_pos, 49);
        check_val("ceil_clamp_state", c_state, 2);
        step_tick(1'b1);
        check_val("ceil_vel0_pos", c_pos, 49);
        step_tick(1'b1);
        check_val("ceil_desc_pos", c_pos, 50);
        n = 0;
        while (c_state == 2'd2 && n < 40) begin
            step_tick(1'b1);
            n++;
        end
        check_val("ceil_land_state", c_state, 1);
        check_val("ceil_land_pos", c_pos, 240);
        c_jump = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dino_motion_ctrl.md
# dino_motion_ctrl

Vertical-motion controller for the dino sprite. Owns the game-state machine (idle, run, air, dead) and the jump physics, and drives the 10-bit `pos` bus that the dino sprite renderer uses as the bottom row of the sprite. Sits between the debounced button and collision logic on one side and the dino sprite renderer on the other. It also produces the leg-animation frame select for the sprite ROM.

## Interface
Parameters:
- `GROUND_Y`, 240: `pos` value when standing on the ground.
- `MIN_Y`, 49: smallest legal `pos` (ceiling); equals the dino sprite height.
- `JUMP_V0`, 12: initial upward velocity in px/tick, 1..127.
- `GRAVITY`, 1: velocity decrement per tick, 1..15.
- `TICK_CYCLES`, 1666667: clk cycles per physics tick (60 Hz at 100 MHz); must be ≥2.
- `ANIM_TICKS`, 6: ticks per leg-animation toggle, ≥1.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse. Starts the game from IDLE and restarts it from DEAD.
- `jump`, in, 1: debounced jump button level.
- `collide`, in, 1: collision flag from the obstacle logic.
- `pos`, out, 10: dino bottom row, registered.
- `state`, out, 2: IDLE=0, RUN=1, AIR=2, DEAD=3, registered.
- `airborne`, out, 1: high exactly when `state`==AIR.
- `run_frame`, out, 1: leg-animation frame select.
- `tick`, out, 1: one-cycle physics tick pulse, exported so scrolling logic can use the same tick.

## Operation
- Tick counter:
  - Free-running, counts 0..TICK_CYCLES-1, then wraps to 0.
  - `tick`=1 in the cycle where count==TICK_CYCLES-1.
  - Runs in every state.
- Jump request latch `jreq`:
  - Set on a rising edge of `jump` (registered previous value; edge = `jump` & ~`jump_d`) when state is RUN.
  - Cleared when consumed, on any state change, and on reset.
  - Edges that occur in IDLE, AIR or DEAD are discarded, so holding the button never auto-repeats.
- Velocity `vel`: signed 8-bit, positive = upward. Position arithmetic uses 11-bit signed: `nxt = pos - vel`.
- IDLE:
  - Holds `pos`=GROUND_Y, `vel`=0, `run_frame`=0.
  - `start` → RUN.
- RUN:
  - On `tick` with `jreq`=1 → AIR, `vel`=JUMP_V0. `pos` is unchanged on this tick.
  - On each `tick`, the animation counter advances. Every ANIM_TICKS ticks, `run_frame` toggles.
- AIR, evaluated on each `tick`:
  - If `nxt` ≥ GROUND_Y: landing. `pos`=GROUND_Y, `vel`=0, → RUN.
  - Else if `nxt` < MIN_Y: ceiling clamp. `pos`=MIN_Y, `vel`=0.
  - Else: `pos`=`nxt`, `vel`=`vel`-GRAVITY.
  - `run_frame` is frozen while in AIR.
- DEAD:
  - `pos`, `vel` and `run_frame` are frozen.
  - `start` → RUN with `pos`=GROUND_Y, `vel`=0, animation counter=0, `run_frame`=0.
- `collide`=1 in RUN or AIR → DEAD at the next edge, regardless of `tick`. `pos` is frozen at its current value.
- Priority, highest first: `rst` > `collide` > tick physics. When `collide` and `tick` occur in the same cycle, the state goes to DEAD and no position update happens.
- `start` in RUN or AIR is ignored. `collide` in IDLE or DEAD is ignored.
- Default trajectory (V0=12, G=1):
  - AIR lasts exactly 25 ticks.
  - Peak `pos`=GROUND_Y-78=162, held after ticks 12 and 13.
  - Lands at tick 25 with `pos`=240.

## Timing
- All outputs are registered; no combinational path from input to output.
- Reset values: `state`=IDLE, `pos`=GROUND_Y, `vel`=0, `airborne`=0, `run_frame`=0, `tick`=0, tick counter=0, `jreq`=0, `jump_d`=0.
- `rst` asserted mid-jump returns the block to IDLE with `pos`=GROUND_Y at the next edge.
- `tick` is high for exactly 1 cycle per TICK_CYCLES cycles. The first `tick` after reset is in cycle TICK_CYCLES-1.
- The physics update is applied at the edge that ends the `tick`-high cycle and is visible the next cycle, together with the next `state`.
- Jump latency:
  - The `jump` edge is latched 1 cycle after `jump` rises.
  - The jump launches on the first `tick` at least one cycle later.
  - The first `pos` change happens one tick after that.
- `collide` → `state`=DEAD: 1 cycle.
- `start` → state change: 1 cycle.

## Test plan
- Reset and idle (TICK_CYCLES=4): hold `rst` 3 cycles → `pos`=240, `state`=0, `run_frame`=0. Next, `tick` pulses in cycles 3, 7, 11 after reset release.
- Full jump: `start`, then pulse `jump` in RUN → `state`=2 for exactly 25 ticks. `pos` sequence begins 240, 228, 217, 207, …; minimum is 162, held for 2 ticks; then `pos`=240 and `state`=1.
- Ceiling clamp (JUMP_V0=100, GROUND_Y=240) → `pos` reaches 140, then clamps to 49 with `vel`=0, then descends back to 240 and returns to RUN.
- Held button: keep `jump`=1 through a landing → no second jump. Release and press again → a new jump launches.
- Collision: `collide` in the same cycle as `tick` during AIR at `pos`=207 → next cycle `state`=3, `pos`=207, unchanged thereafter. `start` → `state`=1, `pos`=240, `run_frame`=0.
- Animation and reset mid-air: with ANIM_TICKS=6 in RUN, `run_frame` toggles every 24 cycles. Assert `rst` in AIR → next cycle `state`=0, `pos`=240, `airborne`=0.
